// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet control slice.
//   ctrl_state_t : sequencer states for one convolution pass
//   INST_*       : inst_w encodings driven into the corelet
//   CNT_BW       : width of the internal sequencing counters
package corelet_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WLOAD,
        WKER,
        WGAP,
        ALOAD,
        EXEC,
        DRAIN,
        NEXT,
        DONE
    } ctrl_state_t;

    localparam logic [2:0] INST_IDLE  = 3'b000;
    localparam logic [2:0] INST_KLOAD = 3'b001;
    localparam logic [2:0] INST_EXEC  = 3'b010;

    localparam int unsigned CNT_BW = 16;

endpackage

// File: rtl/sram_l0_loader.sv
// Streams a block of words from an SRAM into L0.
//   active    : load in progress; counters are held clear while low
//   l0_ready  : L0 can take another word; reads are only issued when high
//   base_addr : SRAM address of the first word
//   len       : number of words to move
//   rd_issue  : SRAM read issued this cycle (drive chip enable low)
//   rd_addr   : SRAM read address, zero when no read is issued
//   l0_wr     : L0 write strobe, the issue strobe delayed by the SRAM latency
//   done      : the last word is being written into L0 this cycle
module sram_l0_loader
    import corelet_pkg::*;
#(
    parameter int unsigned addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               active,
    input  logic               l0_ready,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [CNT_BW-1:0]  len,
    output logic               rd_issue,
    output logic [addr_bw-1:0] rd_addr,
    output logic               l0_wr,
    output logic               done
);

    logic [CNT_BW-1:0] cnt;
    logic [CNT_BW-1:0] wr_cnt;
    logic [CNT_BW-1:0] wr_cnt_next;

    assign rd_issue    = active && l0_ready && (cnt < len);
    assign rd_addr     = rd_issue ? (base_addr + addr_bw'(cnt)) : '0;
    assign wr_cnt_next = wr_cnt + CNT_BW'(l0_wr);
    // Done is flagged in the cycle of the final write so the caller can
    // move on without waiting an extra cycle for wr_cnt to settle.
    assign done        = active && (wr_cnt_next == len);

    always_ff @(posedge clk) begin
        if (reset || !active) begin
            cnt    <= '0;
            wr_cnt <= '0;
            l0_wr  <= 1'b0;
        end else begin
            if (rd_issue) begin
                cnt <= cnt + CNT_BW'(1);
            end
            wr_cnt <= wr_cnt_next;
            l0_wr  <= rd_issue;
        end
    end

endmodule

// File: rtl/corelet_ctrl.sv
// Sequencer for one output-stationary convolution pass. Per kernel index
// it loads weights into L0, issues kernel-load, loads activations, executes
// and drains the OFIFO into psum SRAM.
//   clk, reset            : clock, synchronous active-high reset
//   start_i, busy_o, done_o : host handshake
//   xmem_cen/wen/addr     : activation/weight SRAM read port
//   l0_wr, l0_rd, l0_ready : L0 write/read strobes and back-pressure
//   inst_w                : corelet instruction (kernel load / execute)
//   ofifo_valid, ofifo_rd : OFIFO handshake
//   pmem_cen/wen/addr     : psum SRAM write port
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int unsigned row      = 8,
    parameter int unsigned col      = 8,
    parameter int unsigned len_kij  = 9,
    parameter int unsigned len_nij  = 36,
    parameter int unsigned xaddr_bw = 11,
    parameter int unsigned paddr_bw = 11,
    parameter int unsigned wbase    = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                xmem_cen,
    output logic                xmem_wen,
    output logic [xaddr_bw-1:0] xmem_addr,
    output logic                l0_wr,
    output logic                l0_rd,
    input  logic                l0_ready,
    output logic [2:0]          inst_w,
    input  logic                ofifo_valid,
    output logic                ofifo_rd,
    output logic                pmem_cen,
    output logic                pmem_wen,
    output logic [paddr_bw-1:0] pmem_addr
);

    localparam logic [CNT_BW-1:0] COL_N    = CNT_BW'(col);
    localparam logic [CNT_BW-1:0] NIJ_N    = CNT_BW'(len_nij);
    localparam logic [CNT_BW-1:0] COL_LAST = CNT_BW'(col - 1);
    localparam logic [CNT_BW-1:0] GAP_LAST = CNT_BW'(row + col - 1);
    localparam logic [CNT_BW-1:0] NIJ_LAST = CNT_BW'(len_nij - 1);
    localparam logic [CNT_BW-1:0] KIJ_LAST = CNT_BW'(len_kij - 1);

    ctrl_state_t state;
    ctrl_state_t state_next;

    logic [CNT_BW-1:0]   cnt;
    logic [CNT_BW-1:0]   kij;
    logic                cnt_inc;
    logic                pop;

    logic                ld_active;
    logic                ld_issue;
    logic                ld_done;
    logic [xaddr_bw-1:0] ld_base;
    logic [xaddr_bw-1:0] ld_addr;
    logic [CNT_BW-1:0]   ld_len;

    // WLOAD and ALOAD share one loader; they are never adjacent, so the
    // loader's clear-while-inactive gives a fresh count on each entry.
    assign ld_active = (state == WLOAD) || (state == ALOAD);
    assign ld_base   = (state == WLOAD) ? xaddr_bw'(wbase + col * 32'(kij)) : '0;
    assign ld_len    = (state == WLOAD) ? COL_N : NIJ_N;

    assign pop     = (state == DRAIN) && ofifo_valid && (cnt < NIJ_N);
    assign cnt_inc = (state == WKER) || (state == WGAP) || (state == EXEC) || pop;

    sram_l0_loader #(
        .addr_bw (xaddr_bw)
    ) u_loader (
        .clk       (clk),
        .reset     (reset),
        .active    (ld_active),
        .l0_ready  (l0_ready),
        .base_addr (ld_base),
        .len       (ld_len),
        .rd_issue  (ld_issue),
        .rd_addr   (ld_addr),
        .l0_wr     (l0_wr),
        .done      (ld_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            kij   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_BW'(1);
            end
            if ((state == IDLE) && start_i) begin
                kij <= '0;
            end else if ((state == NEXT) && (kij != KIJ_LAST)) begin
                kij <= kij + CNT_BW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start_i)          state_next = WLOAD;
            WLOAD: if (ld_done)          state_next = WKER;
            WKER:  if (cnt == COL_LAST)  state_next = WGAP;
            WGAP:  if (cnt == GAP_LAST)  state_next = ALOAD;
            ALOAD: if (ld_done)          state_next = EXEC;
            EXEC:  if (cnt == NIJ_LAST)  state_next = DRAIN;
            DRAIN: if (cnt == NIJ_N)     state_next = NEXT;
            NEXT:  state_next = (kij == KIJ_LAST) ? DONE : WLOAD;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        xmem_cen  = !ld_issue;
        xmem_wen  = 1'b1;
        xmem_addr = ld_addr;
        l0_rd     = 1'b0;
        inst_w    = INST_IDLE;
        ofifo_rd  = pop;
        pmem_cen  = !pop;
        pmem_wen  = !pop;
        pmem_addr = pop ? paddr_bw'(len_nij * 32'(kij) + 32'(cnt)) : '0;
        busy_o    = (state != IDLE);
        done_o    = (state == DONE);
        if (state == WKER) begin
            l0_rd  = 1'b1;
            inst_w = INST_KLOAD;
        end else if (state == EXEC) begin
            l0_rd  = 1'b1;
            inst_w = INST_EXEC;
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
module tb_corelet_ctrl;

    localparam int ROW   = 8;
    localparam int COL   = 8;
    localparam int KIJ   = 2;
    localparam int NIJ   = 4;
    localparam int XBW   = 11;
    localparam int PBW   = 11;
    localparam int WBASE = 1024;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start_i = 1'b0;
    logic           busy_o, done_o;
    logic           xmem_cen, xmem_wen;
    logic [XBW-1:0] xmem_addr;
    logic           l0_wr, l0_rd;
    logic           l0_ready = 1'b1;
    logic [2:0]     inst_w;
    logic           ofifo_valid = 1'b1;
    logic           ofifo_rd;
    logic           pmem_cen, pmem_wen;
    logic [PBW-1:0] pmem_addr;

    int n_cmp = 0;
    int n_bad = 0;

    // expected transaction streams for one full pass
    int exp_x[$];
    int exp_p[$];

    int xi, pi, wr_n, kl_n, ex_n, cyc;

    always #5 clk = ~clk;

    corelet_ctrl #(
        .row      (ROW),
        .col      (COL),
        .len_kij  (KIJ),
        .len_nij  (NIJ),
        .xaddr_bw (XBW),
        .paddr_bw (PBW),
        .wbase    (WBASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .xmem_cen    (xmem_cen),
        .xmem_wen    (xmem_wen),
        .xmem_addr   (xmem_addr),
        .l0_wr       (l0_wr),
        .l0_rd       (l0_rd),
        .l0_ready    (l0_ready),
        .inst_w      (inst_w),
        .ofifo_valid (ofifo_valid),
        .ofifo_rd    (ofifo_rd),
        .pmem_cen    (pmem_cen),
        .pmem_wen    (pmem_wen),
        .pmem_addr   (pmem_addr)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".xmem_cen"}, xmem_cen, 1);
        check({tag, ".xmem_wen"}, xmem_wen, 1);
        check({tag, ".pmem_cen"}, pmem_cen, 1);
        check({tag, ".pmem_wen"}, pmem_wen, 1);
        check({tag, ".l0_wr"}, l0_wr, 0);
        check({tag, ".l0_rd"}, l0_rd, 0);
        check({tag, ".ofifo_rd"}, ofifo_rd, 0);
        check({tag, ".inst_w"}, inst_w, 0);
        check({tag, ".busy"}, busy_o, 0);
        check({tag, ".done"}, done_o, 0);
        check({tag, ".xmem_addr"}, xmem_addr, 0);
        check({tag, ".pmem_addr"}, pmem_addr, 0);
    endtask

    // m: 0 = ideal inputs, 1 = 3-cycle l0_ready stall after every 4 reads,
    //    2 = ofifo_valid pattern 1,0,0,1,1,0,1 in drain, 3 = random inputs
    task automatic run_pass(input int m, input bit do_abort);
        bit       prev_issue, issue, in_drain, drain_next, got_done;
        int       stall, pat_i, last_kl, ea, k;
        bit [6:0] pat;
        pat = 7'b1011001;
        xi = 0; pi = 0; wr_n = 0; kl_n = 0; ex_n = 0; cyc = 0;
        prev_issue = 0; stall = 0; pat_i = 0; last_kl = 0; got_done = 0;

        @(posedge clk); #1;
        start_i = 1; l0_ready = 1; ofifo_valid = 1;
        @(negedge clk);
        check("busy_before_start", busy_o, 0);
        @(posedge clk); #1;
        start_i = 0;

        for (int guard = 0; guard < 3000 && !got_done; guard++) begin
            @(negedge clk);
            cyc++;
            issue    = !xmem_cen;
            in_drain = (inst_w != 3'b010) && ex_n > 0 && (ex_n % NIJ) == 0 && pi < ex_n;

            check("busy", busy_o, 1);
            check("xmem_wen", xmem_wen, 1);
            check("l0_wr_latency", l0_wr, prev_issue);
            if (l0_wr) wr_n++;

            if (issue) begin
                check("rd_while_ready", l0_ready, 1);
                ea = (xi < exp_x.size()) ? exp_x[xi] : -1;
                check("xmem_addr", xmem_addr, ea);
                if ((m == 0 || m == 2) && (xi % (COL + NIJ)) == COL)
                    check("wgap_len", cyc - last_kl, ROW + COL + 1);
                xi++;
                if (m == 1 && (xi % 4) == 0) stall = 3;
            end
            prev_issue = issue;

            check("l0_rd", l0_rd, (inst_w == 3'b001 || inst_w == 3'b010) ? 1 : 0);
            check("inst_w_legal", (inst_w == 3'b000 || inst_w == 3'b001 || inst_w == 3'b010) ? 1 : 0, 1);
            if (inst_w == 3'b001) begin
                k = kl_n / COL;
                check("wload_before_kload", wr_n, (k + 1) * COL + k * NIJ);
                kl_n++;
                last_kl = cyc;
            end
            if (inst_w == 3'b010) begin
                k = ex_n / NIJ;
                check("aload_before_exec", wr_n, (k + 1) * (COL + NIJ));
                check("kload_before_exec", kl_n, (k + 1) * COL);
                ex_n++;
                pat_i = 0;
            end

            check("ofifo_rd", ofifo_rd, (ofifo_valid && in_drain) ? 1 : 0);
            check("pmem_cen", pmem_cen, ofifo_rd ? 0 : 1);
            check("pmem_wen", pmem_wen, ofifo_rd ? 0 : 1);
            if (ofifo_rd) begin
                ea = (pi < exp_p.size()) ? exp_p[pi] : -1;
                check("pmem_addr", pmem_addr, ea);
                pi++;
            end

            if (do_abort && ex_n == NIJ + 2) begin
                @(posedge clk); #1;
                reset = 1;
                @(posedge clk); #1;
                reset = 0;
                @(negedge clk);
                check_idle("after_abort");
                return;
            end

            if (done_o) begin
                check("done_after_all_pops", pi, exp_p.size());
                got_done = 1;
                start_i = 1;    // start during DONE must be ignored
            end else begin
                @(posedge clk); #1;
                start_i = (guard == 15);
                drain_next = ex_n > 0 && (ex_n % NIJ) == 0 && pi < ex_n;
                case (m)
                    1: begin
                        l0_ready = (stall == 0);
                        if (stall > 0) stall--;
                        ofifo_valid = 1;
                    end
                    2: begin
                        l0_ready = 1;
                        if (drain_next) begin
                            ofifo_valid = pat[pat_i % 7];
                            pat_i++;
                        end else begin
                            ofifo_valid = 1;
                        end
                    end
                    3: begin
                        l0_ready = ($urandom_range(0, 3) != 0);
                        ofifo_valid = $urandom_range(0, 1);
                    end
                    default: begin
                        l0_ready = 1;
                        ofifo_valid = 1;
                    end
                endcase
            end
        end

        check("done_seen", got_done, 1);
        @(posedge clk); #1;
        start_i = 0;
        @(negedge clk);
        check("busy_after_done", busy_o, 0);
        check("single_done", done_o, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_restart_rd", xmem_cen, 1);
            check("no_restart_busy", busy_o, 0);
        end
        check("xmem_reads", xi, exp_x.size());
        check("l0_writes", wr_n, exp_x.size());
        check("pmem_writes", pi, exp_p.size());
        check("kload_cycles", kl_n, KIJ * COL);
        check("exec_cycles", ex_n, KIJ * NIJ);
    endtask

    initial begin
        for (int k = 0; k < KIJ; k++) begin
            for (int i = 0; i < COL; i++) exp_x.push_back(WBASE + k * COL + i);
            for (int i = 0; i < NIJ; i++) exp_x.push_back(i);
        end
        for (int i = 0; i < KIJ * NIJ; i++) exp_p.push_back(i);

        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check_idle("reset");

        run_pass(0, 0);
        run_pass(1, 0);
        run_pass(2, 0);
        run_pass(0, 1);
        run_pass(0, 0);
        for (int r = 0; r < 3; r++) run_pass(3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
- Sequencer that drives the corelet's control inputs for one output-stationary convolution pass.
- For each kernel index kij it:
  - loads weights from activation/weight SRAM (xmem) into L0;
  - issues kernel-load, then activation load and execute;
  - drains the OFIFO into psum SRAM (pmem).
- Sits between the top-level testbench/host start handshake and the corelet plus its two SRAMs.
- It is the initiator for the corelet's L0 write/read, inst_w and OFIFO read interfaces.

Parameters:
- row, 8, PE array rows; equals the L0 lane count.
- col, 8, PE array columns; equals the number of weight words loaded per kij.
- len_kij, 9, kernel positions per pass.
- len_nij, 36, output pixels per kij. L0 depth must be at least len_nij.
- xaddr_bw, 11, xmem address width.
- paddr_bw, 11, pmem address width.
- wbase, 1024, xmem base address of weights. Activations start at xmem address 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  single-cycle pulse that begins a pass; ignored while busy_o=1
- busy_o  out  1  high from the cycle after start_i until done_o
- done_o  out  1  one-cycle pulse when the pass completes
- xmem_cen  out  1  xmem chip enable, active low
- xmem_wen  out  1  xmem write enable, active low; held 1 (read only)
- xmem_addr  out  xaddr_bw  xmem read address
- l0_wr  out  1  L0 write strobe; the data is xmem Q, one-cycle read latency
- l0_rd  out  1  L0 read strobe
- l0_ready  in  1  L0 can accept a write; deasserts when at most one entry is free
- inst_w  out  3  bit0 = kernel load, bit1 = execute, bit2 = 0
- ofifo_valid  in  1  OFIFO holds a complete row; first-word-fall-through
- ofifo_rd  out  1  OFIFO pop
- pmem_cen  out  1  pmem enable, active low
- pmem_wen  out  1  pmem write enable, active low
- pmem_addr  out  paddr_bw  pmem write address

Behaviour:
- Reset values: all outputs idle.
  - xmem_cen=1, xmem_wen=1, pmem_cen=1, pmem_wen=1.
  - l0_wr=0, l0_rd=0, ofifo_rd=0, inst_w=0, busy_o=0, done_o=0.
  - Addresses=0.
  - FSM in IDLE; counters kij, cnt and wr_cnt are cleared.
  - Reset asserted in any state aborts the pass in the next cycle.
- FSM states: IDLE, WLOAD, WKER, WGAP, ALOAD, EXEC, DRAIN, NEXT, DONE.
- IDLE:
  - start_i=1 leads to WLOAD with kij=0.
- WLOAD:
  - A read is issued (xmem_cen=0, xmem_addr = wbase + kij*col + cnt, cnt++) only in cycles with l0_ready=1 and cnt<col.
  - l0_wr is the issue strobe delayed one cycle.
  - Leave when wr_cnt==col, then go to WKER.
  - Minimum duration with l0_ready always high: col+1 cycles.
- WKER:
  - col cycles of l0_rd=1 with inst_w=3'b001, then go to WGAP.
- WGAP:
  - row+col cycles with inst_w=0 to let weights settle, then go to ALOAD.
- ALOAD:
  - Same rule as WLOAD, but xmem_addr = cnt and the target is len_nij words, then go to EXEC.
- EXEC:
  - len_nij cycles of l0_rd=1 with inst_w=3'b010, then go to DRAIN.
- DRAIN:
  - ofifo_rd is asserted in each cycle where ofifo_valid=1 and cnt<len_nij.
  - In the same cycle: pmem_cen=0, pmem_wen=0, pmem_addr = kij*len_nij + cnt, cnt++.
  - When cnt==len_nij, go to NEXT.
  - No timeout; the controller waits indefinitely for ofifo_valid.
- NEXT:
  - If kij==len_kij-1, go to DONE. Otherwise kij++ and go to WLOAD.
- DONE:
  - done_o=1 for one cycle, then go to IDLE.
- Counters:
  - cnt is cleared on every state entry; wr_cnt is cleared on entry to WLOAD and ALOAD.
  - Address arithmetic is truncated to the address widths.
- Simultaneous events:
  - start_i during DONE is ignored.
  - ofifo_valid during any state other than DRAIN is ignored; data stays in the OFIFO.

Decomposition:
- Shared package (corelet_pkg) holds:
  - the FSM state enum;
  - the inst_w encodings INST_IDLE=3'b000, INST_KLOAD=3'b001, INST_EXEC=3'b010.
- One sub-module, sram_l0_loader, is natural. It contains:
  - the read-issue counter gated by l0_ready;
  - the one-cycle l0_wr delay;
  - wr_cnt and a done flag.
- WLOAD and ALOAD reuse sram_l0_loader with base address and length inputs.

Test Plan:
- Settings: len_kij=2, len_nij=4, col=row=8, l0_ready=1, ofifo_valid=1 whenever DRAIN is active. Pulse start_i. Required responses:
  - xmem addrs 1024..1031, then 0..3, then 1032..1039, then 0..3;
  - pmem addrs 0..7;
  - 8 cycles of inst_w=001 and 4 cycles of inst_w=010 per kij;
  - exactly one done_o pulse.
- Hold l0_ready=0 for 3 cycles mid-WLOAD (after 4 reads). Required responses:
  - no xmem reads and no extra l0_wr during the stall;
  - exactly 8 l0_wr per WLOAD, with addresses contiguous and no duplicates.
- In DRAIN, toggle ofifo_valid 1,0,0,1,1,0,1. Required responses:
  - ofifo_rd mirrors ofifo_valid;
  - pmem_addr increments only on pops;
  - the FSM leaves after exactly 4 pops.
- Assert reset 2 cycles into EXEC of kij=1. Required responses:
  - the next cycle has all outputs at reset values and the FSM in IDLE;
  - a new start_i restarts at xmem addr 1024.
- Pulse start_i while busy_o=1 and again in the done_o cycle. Required response: neither pulse has any effect, and kij does not restart.
